// File: rtl/eq_pkg.sv
// Shared definitions for the equaliser gain stage.
// Holds sample/gain widths, the SPI word field positions, the FSM state type
// and the saturating rescale helper used on both channels.
package eq_pkg;

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned GAIN_W   = 8;
    // Signed sample times unsigned gain fits comfortably in 32 bits.
    localparam int unsigned PROD_W   = 32;
    // Gain is Q1.7, so the product carries 7 fractional bits.
    localparam int unsigned FRAC_W   = 7;

    localparam logic [GAIN_W-1:0] UNITY_GAIN = 8'h80;

    // Field positions inside the 32-bit SPI word.
    localparam int unsigned EQ_GAIN_L_MSB = 31;
    localparam int unsigned EQ_GAIN_L_LSB = 24;
    localparam int unsigned EQ_GAIN_R_MSB = 23;
    localparam int unsigned EQ_GAIN_R_LSB = 16;
    localparam int unsigned EQ_MUTE_BIT   = 15;

    localparam logic signed [PROD_W-1:0] SAT_MAX = 32'sh007F_FFFF;
    localparam logic signed [PROD_W-1:0] SAT_MIN = 32'shFF80_0000;
    localparam logic [SAMPLE_W-1:0] SAT_MAX_S = 24'h7F_FFFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN_S = 24'h80_0000;

    typedef enum logic [1:0] {
        StIdle,
        StMulL,
        StMulR,
        StOut
    } eq_state_e;

    // Drop the Q1.7 fraction (floor) and clip to the signed 24-bit range.
    function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0] scaled;
        logic [SAMPLE_W-1:0]      res;
        scaled = prod >>> FRAC_W;
        if (scaled > SAT_MAX) begin
            res = SAT_MAX_S;
        end else if (scaled < SAT_MIN) begin
            res = SAT_MIN_S;
        end else begin
            res = scaled[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_mult.sv
// Shift-add multiplier: signed SAMPLE_W multiplicand times unsigned GAIN_W
// multiplier, one multiplier bit per clock, LSB first.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   start       load operands and perform the first partial-product step
//   mcand       signed sample operand (sampled only while start is high)
//   mplier      unsigned gain operand (sampled only while start is high)
//   product     signed PROD_W result, valid while done is high and until next start
//   busy        remaining steps are in progress
//   done        1-cycle strobe after the last of the GAIN_W steps
module serial_mult
    import eq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] mcand,
    input  logic [GAIN_W-1:0]   mplier,
    output logic [PROD_W-1:0]   product,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CNT_W = $clog2(GAIN_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(GAIN_W - 1);

    logic [PROD_W-1:0] mcand_ext;
    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] addend_q;
    logic [GAIN_W-1:0] bits_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;

    assign mcand_ext = {{(PROD_W - SAMPLE_W){mcand[SAMPLE_W-1]}}, mcand};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            addend_q <= '0;
            bits_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                // Step 0 is folded into the load so GAIN_W edges cover all bits.
                acc_q    <= mplier[0] ? mcand_ext : '0;
                addend_q <= mcand_ext << 1;
                bits_q   <= mplier >> 1;
                cnt_q    <= CNT_W'(1);
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                acc_q    <= acc_q + (bits_q[0] ? addend_q : '0);
                addend_q <= addend_q << 1;
                bits_q   <= bits_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign product = acc_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: rtl/eq_gain_stage.sv
// Per-channel gain and mute stage between the I2S receiver and the output.
// One serial multiplier is shared: left product first, then right.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   left_in, right_in      signed samples, valid while newsample is high
//   newsample              1-cycle sample strobe
//   eq_vals                SPI word: [31:24] gain_l, [23:16] gain_r, [15] mute
//   eq_done                SPI done, asynchronous; rising edge loads eq_vals
//   left_out, right_out    saturated results, held between strobes
//   out_valid              1-cycle result strobe
//   busy                   a sample is being processed
//   overrun                sticky: a sample arrived while busy and was dropped
module eq_gain_stage
    import eq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                newsample,
    input  logic [31:0]         eq_vals,
    input  logic                eq_done,
    output logic [SAMPLE_W-1:0] left_out,
    output logic [SAMPLE_W-1:0] right_out,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun
);

    eq_state_e state_q, state_d;

    // [0],[1] synchronise eq_done; [2] is the history bit for edge detection.
    logic [2:0] sync_q;
    logic       eq_done_rise;

    logic [GAIN_W-1:0]   shadow_gain_l_q, shadow_gain_r_q;
    logic                shadow_mute_q;
    logic [GAIN_W-1:0]   act_gain_l_q, act_gain_r_q;
    logic                act_mute_q;

    logic [SAMPLE_W-1:0] samp_l_q, samp_r_q;
    logic [SAMPLE_W-1:0] left_res_q;
    logic [SAMPLE_W-1:0] left_out_q, right_out_q;
    logic                overrun_q;

    logic                accept;
    logic                mult_start;
    logic [SAMPLE_W-1:0] mult_mcand;
    logic [GAIN_W-1:0]   mult_mplier;
    logic [PROD_W-1:0]   mult_product;
    logic                mult_busy;
    logic                mult_done;

    logic                eq_vals_unused;
    assign eq_vals_unused = ^eq_vals[EQ_MUTE_BIT-1:0];

    assign eq_done_rise = sync_q[1] & ~sync_q[2];
    assign accept       = (state_q == StIdle) && newsample;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (newsample) state_d = StMulL;
            StMulL: if (mult_done) state_d = StMulR;
            StMulR: if (mult_done) state_d = StOut;
            StOut:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs. The right product is launched in the same cycle the left
    // one completes so the two products run back to back with no gap.
    always_comb begin
        busy        = (state_q != StIdle);
        out_valid   = (state_q == StOut);
        mult_start  = 1'b0;
        mult_mcand  = samp_l_q;
        mult_mplier = act_gain_l_q;
        if (state_q == StMulL) begin
            mult_start = mult_done || !mult_busy;
            if (mult_done) begin
                mult_mcand  = samp_r_q;
                mult_mplier = act_gain_r_q;
            end
        end
    end

    // Coefficient path, sample capture, results and overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q          <= '0;
            shadow_gain_l_q <= UNITY_GAIN;
            shadow_gain_r_q <= UNITY_GAIN;
            shadow_mute_q   <= 1'b0;
            act_gain_l_q    <= UNITY_GAIN;
            act_gain_r_q    <= UNITY_GAIN;
            act_mute_q      <= 1'b0;
            samp_l_q        <= '0;
            samp_r_q        <= '0;
            left_res_q      <= '0;
            left_out_q      <= '0;
            right_out_q     <= '0;
            overrun_q       <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], eq_done};

            // eq_vals is quiet here because ce has just been released.
            if (eq_done_rise) begin
                shadow_gain_l_q <= eq_vals[EQ_GAIN_L_MSB:EQ_GAIN_L_LSB];
                shadow_gain_r_q <= eq_vals[EQ_GAIN_R_MSB:EQ_GAIN_R_LSB];
                shadow_mute_q   <= eq_vals[EQ_MUTE_BIT];
            end

            // Gains are frozen for the whole computation of an accepted sample.
            if (accept) begin
                act_gain_l_q <= shadow_gain_l_q;
                act_gain_r_q <= shadow_gain_r_q;
                act_mute_q   <= shadow_mute_q;
                samp_l_q     <= left_in;
                samp_r_q     <= right_in;
            end

            if (newsample && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end

            if ((state_q == StMulL) && mult_done) begin
                left_res_q <= saturate($signed(mult_product));
            end

            if ((state_q == StMulR) && mult_done) begin
                left_out_q  <= act_mute_q ? '0 : left_res_q;
                right_out_q <= act_mute_q ? '0 : saturate($signed(mult_product));
            end
        end
    end

    serial_mult u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (mult_start),
        .mcand   (mult_mcand),
        .mplier  (mult_mplier),
        .product (mult_product),
        .busy    (mult_busy),
        .done    (mult_done)
    );

    assign left_out  = left_out_q;
    assign right_out = right_out_q;
    assign overrun   = overrun_q;

endmodule
